// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    MERGE,
    WRITE,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane extraction and extension for loads, and lane merge for
// sub-word stores (read-modify-write of a full SRAM word).
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Half-word lanes are little-endian: addr[1] picks the upper or lower half.
  always_comb begin
    byte_lane   = word[{offset, 3'b000} +: 8];
    half_lane   = offset[1] ? word[31:16] : word[15:0];
    load_data   = word;
    merged_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{sign_ext & byte_lane[7]}}, byte_lane};
        merged_word = word;
        merged_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data   = {{16{sign_ext & half_lane[15]}}, half_lane};
        merged_word = word;
        merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_sram_master.sv
// Load/store unit driving a word-wide SRAM that only accepts full-word writes.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module lsu_sram_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  lsu_state_e state, state_nxt;

  logic              we_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, word_q, rdata_q;
  logic [31:0]       load_data, merged_word;
  logic              transfer, wr_word, wr_merge;
  logic [1:0]        size_norm;
  logic [ADDR_W+1:0] addr_in;
  logic              err_in;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
  assign transfer  = req_valid && req_ready;
  assign size_norm = (req_size == 2'd3) ? SZ_WORD : req_size;

`ifdef LSU_MISALIGN_TRAP_EN
  assign err_in  = ((size_norm == SZ_HALF) && req_addr[0]) ||
                   ((size_norm == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign addr_in = req_addr[ADDR_W+1:0];
`else
  // Misaligned requests are silently rounded down to the natural boundary.
  assign err_in = 1'b0;
  always_comb begin
    addr_in = req_addr[ADDR_W+1:0];
    if (size_norm == SZ_HALF) addr_in[0] = 1'b0;
    if (size_norm == SZ_WORD) addr_in[1:0] = 2'b00;
  end
`endif

  lsu_data_align u_align (
    .word        (sram_rdata),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .sign_ext    (signed_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (transfer) begin
        we_q     <= req_we;
        size_q   <= size_norm;
        signed_q <= req_signed;
        err_q    <= err_in;
        addr_q   <= addr_in;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
      end
      if (state == ACCESS && !we_q && !err_q) rdata_q <= load_data;
      if (state == MERGE) word_q <= merged_word;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (transfer) state_nxt = ACCESS;
      ACCESS: begin
        if (!err_q && we_q && size_q != SZ_WORD) state_nxt = MERGE;
        else                                     state_nxt = RESP;
      end
      MERGE:   state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by rst so an in-flight write never lands on the reset edge.
  always_comb begin
    wr_word    = (state == ACCESS) && we_q && (size_q == SZ_WORD) && !err_q;
    wr_merge   = (state == WRITE);
    req_ready  = !rst && (state == IDLE);
    resp_valid = !rst && (state == RESP);
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    sram_addr  = rst ? '0 : addr_q[ADDR_W+1:2];
    sram_wen   = 4'h0;
    sram_wdata = 32'h0;
    if (!rst && wr_word) begin
      sram_wen   = 4'hf;
      sram_wdata = wdata_q;
    end else if (!rst && wr_merge) begin
      sram_wen   = 4'hf;
      sram_wdata = word_q;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign resp_err = resp_valid && err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_sram_master.sv
// Directed self-checking bench for lsu_sram_master with a behavioural word SRAM.
module tb_lsu_sram_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  sram_wen;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic [31:0] mem [0:1023];
  int          wr_count = 0;
  logic [9:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic        partial_seen = 1'b0;

  int checks = 0;
  int failures = 0;

  lsu_sram_master #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  assign sram_rdata = mem[sram_addr];

  always @(posedge clk) begin
    if (sram_wen == 4'hf) begin
      mem[sram_addr] <= sram_wdata;
      wr_count       <= wr_count + 1;
      last_wr_addr   <= sram_addr;
      last_wr_data   <= sram_wdata;
    end
    if (sram_wen != 4'h0 && sram_wen != 4'hf) partial_seen <= 1'b1;
  end

  // Issues one request and waits for its response; lat counts cycles from transfer.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    int waited;
    lat = -1; rdata = 32'hx; err = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("[TB] FAIL req_ready_timeout addr=%h actual=0 required=1", addr);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("[TB] FAIL resp_timeout addr=%h actual=none required=resp_valid", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sram_wen !== 4'h0 || resp_valid !== 1'b0 || sram_addr !== 10'h0 ||
        sram_wdata !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs wen=%h rv=%b addr=%h wd=%h rd=%h err=%b required all zero",
               sram_wen, resp_valid, sram_addr, sram_wdata, resp_rdata, resp_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready actual=%b required=1", req_ready);
    end
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] rd; logic err; int wr0;
    wr0 = wr_count;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, err);
    checks++;
    if (wr_count !== wr0 + 1 || last_wr_addr !== 10'd4 || last_wr_data !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL word_store_write count=%0d addr=%h data=%h required count=%0d addr=004 data=deadbeef",
               wr_count - wr0, last_wr_addr, last_wr_data, 1);
    end
    checks++;
    if (lat !== 2 || rd !== 32'h0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL word_store_resp lat=%0d rdata=%h err=%b required lat=2 rdata=0 err=0", lat, rd, err);
    end
  endtask

  task automatic test_word_load();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, err);
    checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL word_load lat=%0d rdata=%h err=%b required lat=2 rdata=deadbeef err=0", lat, rd, err);
    end
  endtask

  task automatic test_byte_store();
    int lat; logic [31:0] rd; logic err; int wr0;
    wr0 = wr_count;
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA, lat, rd, err);
    checks++;
    if (wr_count !== wr0 + 1 || last_wr_addr !== 10'd4 || last_wr_data !== 32'hDEADAAEF) begin
      failures++;
      $display("[TB] FAIL byte_store_write count=%0d addr=%h data=%h required count=1 addr=004 data=deadaaef",
               wr_count - wr0, last_wr_addr, last_wr_data);
    end
    checks++;
    if (lat !== 4 || rd !== 32'h0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL byte_store_resp lat=%0d rdata=%h err=%b required lat=4 rdata=0 err=0", lat, rd, err);
    end
  endtask

  task automatic test_signed_loads();
    int lat; logic [31:0] rd; logic err;
    logic [1:0]  sz  [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd3};
    logic        sg  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad  [5] = '{32'h11, 32'h12, 32'h13, 32'h10, 32'h10};
    logic [31:0] exp [5] = '{32'hFFFFFFAA, 32'h0000DEAD, 32'h000000DE, 32'hFFFFAAEF, 32'hDEADAAEF};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rd, err);
      checks++;
      if (rd !== exp[i] || lat !== 2 || err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL load_ext_%0d rdata=%h lat=%0d err=%b required rdata=%h lat=2 err=0",
                 i, rd, lat, err, exp[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic err; int wr0;
    wr0 = wr_count;
    do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h00001234, lat, rd, err);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (err !== 1'b1 || lat !== 2 || rd !== 32'h0 || wr_count !== wr0) begin
      failures++;
      $display("[TB] FAIL misalign_trap err=%b lat=%0d rdata=%h writes=%0d required err=1 lat=2 rdata=0 writes=0",
               err, lat, rd, wr_count - wr0);
    end
`else
    checks++;
    if (err !== 1'b0 || lat !== 4 || wr_count !== wr0 + 1 ||
        last_wr_addr !== 10'd4 || last_wr_data !== 32'h1234AAEF) begin
      failures++;
      $display("[TB] FAIL misalign_fix err=%b lat=%0d writes=%0d addr=%h data=%h required err=0 lat=4 writes=1 addr=004 data=1234aaef",
               err, lat, wr_count - wr0, last_wr_addr, last_wr_data);
    end
`endif
  endtask

  task automatic test_reset_during_write();
    int lat; logic [31:0] rd; logic err; int wr0;
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, lat, rd, err);
    wr0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sram_wen !== 4'hf) begin
      failures++;
      $display("[TB] FAIL rst_write_reached wen=%h required=f", sram_wen);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sram_wen !== 4'h0) begin
      failures++;
      $display("[TB] FAIL rst_write_gated wen=%h required=0", sram_wen);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || wr_count !== wr0 || mem[8] !== 32'h11223344) begin
      failures++;
      $display("[TB] FAIL rst_abort ready=%b rv=%b writes=%0d mem=%h required ready=1 rv=0 writes=0 mem=11223344",
               req_ready, resp_valid, wr_count - wr0, mem[8]);
    end
  endtask

  task automatic test_back_to_back();
    int xfers, pulses, prev, gaps_bad, data_bad;
    xfers = 0; pulses = 0; prev = -1; gaps_bad = 0; data_bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (resp_valid) begin
        pulses++;
        if (prev >= 0 && cyc - prev != 3) gaps_bad++;
        if (resp_rdata !== 32'h11223344) data_bad++;
        prev = cyc;
      end
      if (req_valid && req_ready) xfers++;
      @(posedge clk); #1;
      if (xfers >= 6) req_valid = 1'b0;
    end
    checks++;
    if (pulses !== 6) begin
      failures++;
      $display("[TB] FAIL b2b_pulses actual=%0d required=6", pulses);
    end
    checks++;
    if (gaps_bad !== 0 || data_bad !== 0) begin
      failures++;
      $display("[TB] FAIL b2b_spacing bad_gaps=%0d bad_data=%0d required 0 and 0", gaps_bad, data_bad);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_word_load();
    test_byte_store();
    test_signed_loads();
    test_misaligned();
    test_reset_during_write();
    test_back_to_back();
    checks++;
    if (partial_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL partial_wen actual=1 required=0");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
